tabla_checker: RTL and testbench

Hardware self-checking truth-table verifier: the response-side counterpart of our exhaustive truth-table test benches. It drives every input combination of a small combinational block (up to 4 inputs) in ascending binary order, waits a programmable settle time, samples the block's single output and compares it against a latched expected truth table. It reports pass/fail, mismatch count and first failing index, so table modules (3- and 4-input) can be checked on-chip or in simulation without a `$monitor` dump.

---
 rtl/tabla_checker.sv | 86 ++++++++
 tb/tb_tabla_checker.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tabla_checker.sv
// tabla_checker: sweeps all 2**N_IN input vectors, samples dut_y after SETTLE cycles, checks it against a latched truth table.
// Define TT_STOP_ON_FAIL_EN to end the run at the first mismatch.
module tabla_checker #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   input  logic                 dut_y,
   output logic [N_IN-1:0]      stim,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_count,
   output logic                 first_err_vld,
   output logic [N_IN-1:0]      first_err_idx
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [3:0] SMAX = 4'(SETTLE - 1);
   state_t state, state_nx;
   logic [2**N_IN-1:0] exp_r;
   logic [3:0] cnt;
   logic smp, miss, fin;
   always_comb begin
      smp  = (state == RUN) && (cnt == SMAX);
      // X/Z on dut_y must count as a mismatch
      miss = smp && (dut_y !== exp_r[stim]);
`ifdef TT_STOP_ON_FAIL_EN
      fin  = smp && ((&stim) || miss);
`else
      fin  = smp && (&stim);
`endif
      state_nx = (state == IDLE && start) ? RUN :
                 (state == RUN && fin)    ? DONE :
                 (state == DONE)          ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_r         <= '0;
         stim          <= '0;
         cnt           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         first_err_vld <= 1'b0;
         first_err_idx <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               exp_r         <= expected;
               stim          <= '0;
               cnt           <= '0;
               err_count     <= '0;
               pass          <= 1'b0;
               first_err_vld <= 1'b0;
               first_err_idx <= '0;
               busy          <= 1'b1;
            end
            RUN: begin
               cnt <= smp ? 4'd0 : cnt + 4'd1;
               if (miss) begin
                  err_count <= err_count + 1'b1;
                  if (!first_err_vld) begin
                     first_err_vld <= 1'b1;
                     first_err_idx <= stim;
                  end
               end
               if (fin) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= (err_count == '0) && !miss;
               end else if (smp) begin
                  stim <= stim + 1'b1;
               end
            end
            default: done <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_tabla_checker.sv
// tb_tabla_checker: table-driven and randomized checks of tabla_checker (N_IN=3/SETTLE=1 and N_IN=4/SETTLE=3).
module tb_tabla_checker;
   logic clk = 1'b0, rst_n = 1'b0, start_r = 1'b0, sel = 1'b0;
   logic [7:0] exp3 = '0, act3 = '0;
   logic [15:0] exp4 = '0, act4 = '0;
   logic [2:0] stim3, fi3;
   logic [3:0] stim4, fi4, err3;
   logic [4:0] err4;
   logic busy3, done3, pass3, fv3, busy4, done4, pass4, fv4;
   logic [3:0] stim_s, fi_s;
   logic [4:0] err_s;
   logic busy_s, done_s, pass_s, fv_s, start3, start4, y3, y4;
   int checks = 0, errors = 0;

   assign start3 = start_r & ~sel;
   assign start4 = start_r & sel;
   assign y3 = act3[stim3];
   assign y4 = act4[stim4];
   assign stim_s = sel ? stim4 : {1'b0, stim3};
   assign fi_s   = sel ? fi4 : {1'b0, fi3};
   assign err_s  = sel ? err4 : {1'b0, err3};
   assign busy_s = sel ? busy4 : busy3;
   assign done_s = sel ? done4 : done3;
   assign pass_s = sel ? pass4 : pass3;
   assign fv_s   = sel ? fv4 : fv3;

   tabla_checker #(.N_IN(3), .SETTLE(1)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .dut_y(y3),
      .stim(stim3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
      .first_err_vld(fv3), .first_err_idx(fi3));
   tabla_checker #(.N_IN(4), .SETTLE(3)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .expected(exp4), .dut_y(y4),
      .stim(stim4), .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
      .first_err_vld(fv4), .first_err_idx(fi4));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, got, want);
      end
   endtask

   // reference: full-sweep mismatch count and first differing vector
   function automatic void model(input bit s, input logic [15:0] e, input logic [15:0] a,
                                 output int err, output int fi);
      err = 0;
      fi  = -1;
      for (int i = 0; i < (s ? 16 : 8); i++)
         if (e[i] !== a[i]) begin
            err++;
            if (fi < 0) fi = i;
         end
   endfunction

   task automatic do_run(input string nm, input bit s, input logic [15:0] e, input logic [15:0] a,
                         input int err_in, input int fi, input bit poke);
      int nv, st, cyc, endv, k, nd, err;
      bit ok;
      err = err_in;
      nv = s ? 16 : 8;
      st = s ? 3 : 1;
`ifdef TT_STOP_ON_FAIL_EN
      if (err > 0) err = 1;
      cyc  = (err > 0) ? (fi + 1) * st : nv * st;
      endv = (err > 0) ? fi : nv - 1;
`else
      cyc  = nv * st;
      endv = nv - 1;
`endif
      @(negedge clk);
      sel = s;
      if (s) begin exp4 = e; act4 = a; end
      else begin exp3 = e[7:0]; act3 = a[7:0]; end
      start_r = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_r = 1'b0;
      if (s) exp4 = ~e; else exp3 = ~e[7:0];
      ok = (busy_s === 1'b1) && (stim_s === 4'd0) && (err_s === 5'd0) && (pass_s === 1'b0) && (fv_s === 1'b0);
      k = 0;
      nd = 0;
      while (k < cyc + 2) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (poke) start_r = (k == 3 || k == 5) && (k + 1 < cyc);
         if (done_s === 1'b1) begin
            nd++;
            if (k != cyc) ok = 1'b0;
         end
         if (busy_s !== (k < cyc)) ok = 1'b0;
         if (stim_s !== 4'(k < cyc ? k / st : endv)) ok = 1'b0;
      end
      start_r = 1'b0;
      chk({nm, " traj"}, 32'(ok), 32'd1);
      chk({nm, " done_pulses"}, 32'(nd), 32'd1);
      chk({nm, " err_count"}, 32'(err_s), 32'(err));
      chk({nm, " pass"}, 32'(pass_s), 32'(err == 0));
      chk({nm, " first_vld"}, 32'(fv_s), 32'(err > 0));
      chk({nm, " first_idx"}, 32'(fi_s), 32'(err > 0 ? fi : 0));
   endtask

   typedef struct {
      bit s;
      logic [15:0] e, a;
      int err, fi;
      bit poke;
   } vec_t;
   vec_t tbl[6];

   initial begin
      int err, fi, n;
      logic [15:0] e, a;
      bit s;
      tbl[0] = '{1'b0, 16'h0096, 16'h0096, 0, -1, 1'b1};
      tbl[1] = '{1'b0, 16'h0096, 16'h0000, 4, 1, 1'b0};
      tbl[2] = '{1'b0, 16'h00FF, 16'h0080, 7, 0, 1'b0};
      tbl[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 0, -1, 1'b1};
      tbl[4] = '{1'b1, 16'hFFFF, 16'h0000, 16, 0, 1'b0};
      tbl[5] = '{1'b0, 16'h0000, 16'h00FF, 8, 0, 1'b0};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset3", 32'({stim3, busy3, done3, pass3, err3, fv3, fi3}), 32'd0);
      chk("reset4", 32'({stim4, busy4, done4, pass4, err4, fv4, fi4}), 32'd0);
      rst_n = 1'b1;
      foreach (tbl[i])
         do_run($sformatf("tbl%0d", i), tbl[i].s, tbl[i].e, tbl[i].a, tbl[i].err, tbl[i].fi, tbl[i].poke);
      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom_range(0, 1));
         e = 16'($urandom);
         a = ($urandom_range(0, 3) == 0) ? e : 16'($urandom);
         if (!s) begin e[15:8] = '0; a[15:8] = '0; end
         model(s, e, a, err, fi);
         do_run($sformatf("rand%0d", i), s, e, a, err, fi, 1'b0);
      end
      // asynchronous reset in the middle of a sweep
      @(negedge clk);
      sel = 1'b0;
      exp3 = 8'h96;
      act3 = 8'h96;
      start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      for (int i = 0; i < 20 && stim3 != 3'd5; i++) @(negedge clk);
      chk("reach5", 32'(stim3), 32'd5);
      #2 rst_n = 1'b0;
      #1 chk("async_rst", 32'({stim3, busy3, done3, pass3, err3, fv3, fi3}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (done3 !== 1'b0 || busy3 !== 1'b0) n++;
      end
      chk("idle_after_rst", 32'(n), 32'd0);
      do_run("restart", 1'b0, 16'h0096, 16'h0000, 4, 1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
